calendar_day_counter: RTL
=========================

// Module: calendar_day_counter
// PURPOSE
//  Calendar date counter clocked by the divided tick clk_out; one enabled edge = one day.
//  Keeps month, BCD day digits and day-of-year for the month/day seven-segment display stage.
//  Handles 28/29/30/31-day months, leap years and the Dec 31 -> Jan 1 wrap.
//  Feeds dualSevenSeg (day digits) and the month segment decoder directly.
// PARAMETERS
//  DOY_W    9  width of day_of_year (must hold 366)
//  MONTH_W  4  width of month (must hold 12)
// PORTS
//  clk_out      in   1        divided day-tick clock, rising-edge active
//  reset_n      in   1        asynchronous, active-low reset
//  run          in   1        1 = advance one day per clk_out edge; 0 = hold
//  clr          in   1        synchronous return to Jan 1 (doy 1)
//  leap         in   1        leap-year select (SW[9]); sampled only while date is Jan 1
//  dir          in   1        1 = count down; present only with CAL_DOWN_COUNT_EN
//  month        out  MONTH_W  1..12, binary
//  day_tens     out  4        BCD tens of day-of-month, 0..3
//  day_ones     out  4        BCD ones of day-of-month, 0..9
//  day_of_year  out  DOY_W    1..365 (1..366 when leap_q)
//  leap_q       out  1        latched leap flag used by the counter
//  year_wrap    out  1        one-cycle pulse on the edge that wraps the year
//  heartbeat    out  1        toggles on every advancing edge (LED)
// BEHAVIOUR
//  - Reset (async assert, outputs immediate): month=1, day=01, doy=1, leap_q=0, year_wrap=0, heartbeat=0.
//  - All outputs registered; a change takes effect on the same clk_out edge that samples run=1. Latency is 0 extra cycles.
//  - Priority per edge: clr > run > hold. clr: date=Jan 1, doy=1, year_wrap=0. heartbeat and leap_q are unchanged by clr.
//  - leap_q <= leap on every edge on which the registered date is Jan 1 (run is ignored).
//    leap_q is fixed for the rest of the year, so doy and month/day always stay consistent.
//  - Month length: 31 (1,3,5,7,8,10,12), 30 (4,6,9,11), Feb = leap_q ? 29 : 28.
//  - Up step: if day < mlen then day+1, else day=1 and month+1.
//    Month 12 at day 31 wraps to Jan 1, doy=1, year_wrap=1 for that cycle only.
//    Otherwise doy+1.
//  - Day is held as a BCD pair. Ones 9 -> 0 carries into tens. The month rollover compares against mlen in binary. No invalid BCD value (ones>9, tens>3) is ever produced.
//  - year_wrap is 0 on every edge without a wrap. heartbeat toggles on every edge with run=1 and clr=0.
//  - Reset mid-operation: state goes immediately to the reset values, and no year_wrap pulse is produced.
//  - run=0: all state holds. leap_q may still load while the date is Jan 1.
// CONFIGURATION
//  CAL_DOWN_COUNT_EN defined: dir port exists.
//    dir=1 step: day>1 -> day-1. day==1 -> previous month's last day.
//    Jan 1 -> Dec 31 with doy = leap_q?366:365 and year_wrap=1.
//    Otherwise doy-1.
//  Undefined: no dir port; always counts up.
// STRUCTURE
//  - calendar_pkg holds the month constants (JAN..DEC), the month-length table function month_len(month, leap), DAYS_NORM=365 and DAYS_LEAP=366.
//  - Sub-module month_length_lut (combinational): month, leap_q -> 5-bit mlen.
//    The down-count path uses it a second time for month-1.
//  - Top of block: one sequential always for the date, leap_q, year_wrap and heartbeat registers, plus the next-state logic.
// TESTING
//  - Reset, then release with run=0 for 5 edges -> month=1, day=01, doy=1, heartbeat=0, no year_wrap.
//  - leap=0, run=1 for 31 edges -> Feb 01, doy=32. 27 more edges -> Feb 28, doy=59. 1 more -> Mar 01, doy=60.
//  - leap=1 at Jan 1, run 59 edges -> Feb 29, doy=60. Next edge -> Mar 01, doy=61. Toggling leap mid-year leaves leap_q=1.
//  - Non-leap year, 364 edges -> Dec 31, doy=365. Next edge -> Jan 01, doy=1, year_wrap=1 for exactly 1 cycle.
//  - clr=1 and run=1 on the same edge at Jun 15 -> Jan 01, doy=1, heartbeat unchanged.
//    reset_n pulsed low mid-year -> immediate Jan 01.
//  - CAL_DOWN_COUNT_EN, dir=1, leap_q=1 at Jan 1 -> Dec 31, doy=366, year_wrap=1.
//    Mar 01 -> Feb 29, doy=60.

Source files
------------

// File: rtl/calendar_day_counter_pkg.sv
// calendar_pkg: month constants, month-length table and year lengths shared by the
// calendar day counter and its month-length lookup. Rev 1.0
`default_nettype none

package calendar_pkg;

   localparam logic [3:0] JAN = 4'd1;
   localparam logic [3:0] FEB = 4'd2;
   localparam logic [3:0] MAR = 4'd3;
   localparam logic [3:0] APR = 4'd4;
   localparam logic [3:0] MAY = 4'd5;
   localparam logic [3:0] JUN = 4'd6;
   localparam logic [3:0] JUL = 4'd7;
   localparam logic [3:0] AUG = 4'd8;
   localparam logic [3:0] SEP = 4'd9;
   localparam logic [3:0] OCT = 4'd10;
   localparam logic [3:0] NOV = 4'd11;
   localparam logic [3:0] DEC = 4'd12;

   localparam int DAYS_NORM = 365;
   localparam int DAYS_LEAP = 366;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_day_t;

   function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
      case (month)
         FEB:                month_len = leap ? 5'd29 : 5'd28;
         APR, JUN, SEP, NOV: month_len = 5'd30;
         default:            month_len = 5'd31;
      endcase
   endfunction

   // Month lengths are always 28..31, so tens is 2 or 3.
   function automatic bcd_day_t mlen_to_bcd(input logic [4:0] mlen);
      bcd_day_t v;
      if (mlen >= 5'd30) begin
         v.tens = 4'd3;
         v.ones = 4'(mlen - 5'd30);
      end else begin
         v.tens = 4'd2;
         v.ones = 4'(mlen - 5'd20);
      end
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/calendar_day_counter_if.sv
// calendar_day_counter_if: control inputs and date outputs of the day counter.
// dir exists only when CAL_DOWN_COUNT_EN is defined. Rev 1.0
`default_nettype none

interface calendar_day_counter_if #(
   parameter int DOY_W   = 9,
   parameter int MONTH_W = 4
);
   logic               run;
   logic               clr;
   logic               leap;
`ifdef CAL_DOWN_COUNT_EN
   logic               dir;
`endif
   logic [MONTH_W-1:0] month;
   logic [3:0]         day_tens;
   logic [3:0]         day_ones;
   logic [DOY_W-1:0]   day_of_year;
   logic               leap_q;
   logic               year_wrap;
   logic               heartbeat;

   modport master (
      output run, clr, leap,
`ifdef CAL_DOWN_COUNT_EN
      output dir,
`endif
      input  month, day_tens, day_ones, day_of_year, leap_q, year_wrap, heartbeat
   );

   modport slave (
      input  run, clr, leap,
`ifdef CAL_DOWN_COUNT_EN
      input  dir,
`endif
      output month, day_tens, day_ones, day_of_year, leap_q, year_wrap, heartbeat
   );
endinterface

`default_nettype wire

// File: rtl/calendar_day_counter_month_length_lut.sv
// month_length_lut: combinational month -> days-in-month lookup. Rev 1.0
`default_nettype none

module month_length_lut
   import calendar_pkg::*;
(
   input  wire logic [3:0] i_month,
   input  wire logic       i_leap,
   output logic      [4:0] o_mlen
);
   assign o_mlen = month_len(i_month, i_leap);
endmodule

`default_nettype wire

// File: rtl/calendar_day_counter.sv
// calendar_day_counter: one day per enabled clk_out edge; BCD day, month, day-of-year.
// Optional down counting with CAL_DOWN_COUNT_EN. Rev 1.0
`default_nettype none

module calendar_day_counter
   import calendar_pkg::*;
#(
   parameter int DOY_W   = 9,
   parameter int MONTH_W = 4
) (
   input  wire logic             clk_out,
   input  wire logic             reset_n,
   calendar_day_counter_if.slave bus
);

   logic [MONTH_W-1:0] r_month;
   logic [3:0]         r_day_tens;
   logic [3:0]         r_day_ones;
   logic [DOY_W-1:0]   r_doy;
   logic               r_leap_q;
   logic               r_year_wrap;
   logic               r_heartbeat;

   logic [MONTH_W-1:0] w_month_nxt;
   logic [3:0]         w_day_tens_nxt;
   logic [3:0]         w_day_ones_nxt;
   logic [DOY_W-1:0]   w_doy_nxt;
   logic               w_year_wrap_nxt;
   logic               w_heartbeat_nxt;

   logic               w_is_jan1;
   logic               w_leap_nxt;
   logic [5:0]         w_day_bin;
   logic [4:0]         w_mlen_cur;

   assign w_is_jan1  = (r_month == MONTH_W'(JAN)) && (r_day_tens == 4'd0) && (r_day_ones == 4'd1);
   // The year length is frozen by whatever leap value is latched while sitting on Jan 1.
   assign w_leap_nxt = w_is_jan1 ? bus.leap : r_leap_q;
   assign w_day_bin  = 6'(r_day_tens) * 6'd10 + 6'(r_day_ones);

   month_length_lut u_mlen_cur (
      .i_month (4'(r_month)),
      .i_leap  (w_leap_nxt),
      .o_mlen  (w_mlen_cur)
   );

`ifdef CAL_DOWN_COUNT_EN
   logic [3:0]         w_month_prev;
   logic [4:0]         w_mlen_prev;
   bcd_day_t           w_prev_last;

   assign w_month_prev = (r_month == MONTH_W'(JAN)) ? DEC : 4'(r_month) - 4'd1;
   assign w_prev_last  = mlen_to_bcd(w_mlen_prev);

   month_length_lut u_mlen_prev (
      .i_month (w_month_prev),
      .i_leap  (w_leap_nxt),
      .o_mlen  (w_mlen_prev)
   );
`endif

   always_comb begin
      w_month_nxt     = r_month;
      w_day_tens_nxt  = r_day_tens;
      w_day_ones_nxt  = r_day_ones;
      w_doy_nxt       = r_doy;
      w_year_wrap_nxt = 1'b0;
      w_heartbeat_nxt = r_heartbeat;

      if (bus.clr) begin
         w_month_nxt    = MONTH_W'(JAN);
         w_day_tens_nxt = 4'd0;
         w_day_ones_nxt = 4'd1;
         w_doy_nxt      = DOY_W'(1);
      end else if (bus.run) begin
         w_heartbeat_nxt = ~r_heartbeat;
`ifdef CAL_DOWN_COUNT_EN
         if (bus.dir) begin
            if (w_day_bin > 6'd1) begin
               if (r_day_ones == 4'd0) begin
                  w_day_tens_nxt = r_day_tens - 4'd1;
                  w_day_ones_nxt = 4'd9;
               end else begin
                  w_day_ones_nxt = r_day_ones - 4'd1;
               end
               w_doy_nxt = r_doy - DOY_W'(1);
            end else begin
               w_month_nxt    = MONTH_W'(w_month_prev);
               w_day_tens_nxt = w_prev_last.tens;
               w_day_ones_nxt = w_prev_last.ones;
               if (r_month == MONTH_W'(JAN)) begin
                  w_doy_nxt       = w_leap_nxt ? DOY_W'(DAYS_LEAP) : DOY_W'(DAYS_NORM);
                  w_year_wrap_nxt = 1'b1;
               end else begin
                  w_doy_nxt = r_doy - DOY_W'(1);
               end
            end
         end else begin
`else
         begin
`endif
            if (w_day_bin < {1'b0, w_mlen_cur}) begin
               if (r_day_ones == 4'd9) begin
                  w_day_tens_nxt = r_day_tens + 4'd1;
                  w_day_ones_nxt = 4'd0;
               end else begin
                  w_day_ones_nxt = r_day_ones + 4'd1;
               end
               w_doy_nxt = r_doy + DOY_W'(1);
            end else begin
               w_day_tens_nxt = 4'd0;
               w_day_ones_nxt = 4'd1;
               if (r_month == MONTH_W'(DEC)) begin
                  w_month_nxt     = MONTH_W'(JAN);
                  w_doy_nxt       = DOY_W'(1);
                  w_year_wrap_nxt = 1'b1;
               end else begin
                  w_month_nxt = r_month + MONTH_W'(1);
                  w_doy_nxt   = r_doy + DOY_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         r_month     <= MONTH_W'(JAN);
         r_day_tens  <= 4'd0;
         r_day_ones  <= 4'd1;
         r_doy       <= DOY_W'(1);
         r_leap_q    <= 1'b0;
         r_year_wrap <= 1'b0;
         r_heartbeat <= 1'b0;
      end else begin
         r_month     <= w_month_nxt;
         r_day_tens  <= w_day_tens_nxt;
         r_day_ones  <= w_day_ones_nxt;
         r_doy       <= w_doy_nxt;
         r_leap_q    <= w_leap_nxt;
         r_year_wrap <= w_year_wrap_nxt;
         r_heartbeat <= w_heartbeat_nxt;
      end
   end

   assign bus.month       = r_month;
   assign bus.day_tens    = r_day_tens;
   assign bus.day_ones    = r_day_ones;
   assign bus.day_of_year = r_doy;
   assign bus.leap_q      = r_leap_q;
   assign bus.year_wrap   = r_year_wrap;
   assign bus.heartbeat   = r_heartbeat;

endmodule

`default_nettype wire
